sync_fifo: RTL and testbench

Parametrised synchronous FIFO, successor to the basic single-clock FIFO. Adds non-power-of-two depth, selectable standard or first-word-fall-through (FWFT) read mode, fill count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. Used as the general-purpose single-clock buffer between pipeline stages and peripherals.

---
 rtl/sync_fifo.sv | 124 ++++++++++++
 tb/tb_sync_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, fill count, almost-full/almost-empty thresholds, flush and sticky errors.
module sync_fifo #(
  parameter  int DATAW  = 8,
  parameter  int DEPTH  = 5,
  parameter  bit FWFT   = 1'b0,
  parameter  int AF_LVL = DEPTH - 1,
  parameter  int AE_LVL = 1,
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_clr_err,
  input  logic             i_wr_en,
  input  logic [DATAW-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [DATAW-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CNTW-1:0]  o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem_q [DEPTH];

  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [DATAW-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty, wr_acc, rd_acc;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign full   = (count_q == CNTW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = i_wr_en && !full  && !i_flush;
  assign rd_acc = i_rd_en && !empty && !i_flush;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc)      count_d = count_q + CNTW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNTW'(1);
    end

    if (!FWFT && rd_acc) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    // Clear first so a same-cycle offending access wins.
    if (i_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (i_wr_en && full  && !i_flush) overflow_d  = 1'b1;
    if (i_rd_en && empty && !i_flush) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data      = FWFT ? mem_q[rd_ptr_q] : rd_data_q;
  assign o_rd_valid     = FWFT ? !empty : rd_valid_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= CNTW'(AF_LVL));
  assign o_almost_empty = (count_q <= CNTW'(AE_LVL));
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode and an FWFT instance (DEPTH=5)
// driven from vector tables, plus async-reset and reset-state sequences.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_flush, s_clr, s_wr, s_rd;
  logic [7:0] s_wdata, s_rdata;
  logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_count;

  logic       f_flush, f_clr, f_wr, f_rd;
  logic [7:0] f_wdata, f_rdata;
  logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  sync_fifo #(.DATAW(8), .DEPTH(5), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .i_flush(s_flush), .i_clr_err(s_clr),
    .i_wr_en(s_wr), .i_wr_data(s_wdata), .i_rd_en(s_rd),
    .o_rd_data(s_rdata), .o_rd_valid(s_rvalid), .o_full(s_full), .o_empty(s_empty),
    .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  sync_fifo #(.DATAW(8), .DEPTH(5), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .i_flush(f_flush), .i_clr_err(f_clr),
    .i_wr_en(f_wr), .i_wr_data(f_wdata), .i_rd_en(f_rd),
    .o_rd_data(f_rdata), .o_rd_valid(f_rvalid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  // Observation word: {rdata[17:10], rvalid, full, empty, af, ae, count[4:2], ovf, unf}
  logic [17:0] s_obs, f_obs;
  assign s_obs = {s_rdata, s_rvalid, s_full, s_empty, s_af, s_ae, s_count, s_ovf, s_unf};
  assign f_obs = {f_rdata, f_rvalid, f_full, f_empty, f_af, f_ae, f_count, f_ovf, f_unf};

  typedef struct {
    logic        fw;
    logic        wr, rd, flush, clr;
    logic [7:0]  wdata;
    logic [17:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Expected word for DEPTH=5, AF_LVL=4, AE_LVL=1.
  function automatic logic [17:0] ex(input logic [7:0] rdata, input logic rv,
                                     input int cnt, input logic ovf, input logic unf);
    return {rdata, rv, cnt == 5, cnt == 0, cnt >= 4, cnt <= 1, 3'(cnt), ovf, unf};
  endfunction

  function automatic vec_t mk(input logic fw, input logic wr, input logic rd,
                              input logic flush, input logic clr, input logic [7:0] wdata,
                              input logic [17:0] exp);
    vec_t v;
    v.fw = fw; v.wr = wr; v.rd = rd; v.flush = flush; v.clr = clr;
    v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [17:0] act,
                       input logic [17:0] exp, input logic [17:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_clr = 0; s_wr = 0; s_rd = 0; s_wdata = '0;
    f_flush = 0; f_clr = 0; f_wr = 0; f_rd = 0; f_wdata = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic std_op(input logic wr, input logic rd, input logic [7:0] wd);
    idle_inputs();
    s_wr = wr; s_rd = rd; s_wdata = wd;
    cycle();
  endtask

  localparam logic [17:0] ALL     = '1;
  localparam logic [17:0] NO_DATA = 18'h003FF;

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_std",  s_obs, ex(8'h00, 0, 0, 0, 0), ALL);
    check("reset_fwft", f_obs, ex(8'h00, 0, 0, 0, 0), NO_DATA);
    rst_n = 1'b1;
    cycle();
    check("idle_std", s_obs, ex(8'h00, 0, 0, 0, 0), ALL);

    // Standard mode: fill, overflow, read out, underflow, clear.
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h11, ex(8'h00, 0, 1, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h22, ex(8'h00, 0, 2, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h33, ex(8'h00, 0, 3, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h44, ex(8'h00, 0, 4, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h55, ex(8'h00, 0, 5, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h66, ex(8'h00, 0, 5, 1, 0)));
    // Write while full rejected despite concurrent read; set beats clear.
    vq.push_back(mk(0, 1, 1, 0, 1, 8'h77, ex(8'h11, 1, 4, 1, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h22, 1, 3, 1, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h33, 1, 2, 1, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h44, 1, 1, 1, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h55, 1, 0, 1, 0)));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, ex(8'h55, 0, 0, 1, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h55, 0, 0, 1, 1)));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, ex(8'h55, 0, 0, 0, 0)));
    // Wrap-around: offset pointers by 3, then streaming write+read.
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h01, ex(8'h55, 0, 1, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h02, ex(8'h55, 0, 2, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h03, ex(8'h55, 0, 3, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h01, 1, 2, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h02, 1, 1, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h03, 1, 0, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'hA0, ex(8'h03, 0, 1, 0, 0)));
    vq.push_back(mk(0, 1, 1, 0, 0, 8'hA1, ex(8'hA0, 1, 1, 0, 0)));
    vq.push_back(mk(0, 1, 1, 0, 0, 8'hA2, ex(8'hA1, 1, 1, 0, 0)));
    vq.push_back(mk(0, 1, 1, 0, 0, 8'hA3, ex(8'hA2, 1, 1, 0, 0)));
    vq.push_back(mk(0, 1, 1, 0, 0, 8'hA4, ex(8'hA3, 1, 1, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'hA4, 1, 0, 0, 0)));
    // Flush at count 3 with concurrent write and read.
    vq.push_back(mk(0, 1, 0, 0, 0, 8'hB1, ex(8'hA4, 0, 1, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'hB2, ex(8'hA4, 0, 2, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'hB3, ex(8'hA4, 0, 3, 0, 0)));
    vq.push_back(mk(0, 1, 1, 1, 0, 8'hEE, ex(8'hA4, 0, 0, 0, 0)));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h7E, ex(8'hA4, 0, 1, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, ex(8'h7E, 1, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, ex(8'h7E, 0, 0, 0, 0)));
    vq.push_back(mk(0, 0, 1, 0, 1, 8'h00, ex(8'h7E, 0, 0, 0, 1)));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, ex(8'h7E, 0, 0, 0, 0)));
    // FWFT: fall-through, simultaneous pop+write at count 1, underflow.
    vq.push_back(mk(1, 1, 0, 0, 0, 8'h3C, ex(8'h3C, 1, 1, 0, 0)));
    vq.push_back(mk(1, 0, 0, 0, 0, 8'h00, ex(8'h3C, 1, 1, 0, 0)));
    vq.push_back(mk(1, 1, 1, 0, 0, 8'h5A, ex(8'h5A, 1, 1, 0, 0)));
    vq.push_back(mk(1, 1, 0, 0, 0, 8'h6B, ex(8'h5A, 1, 2, 0, 0)));
    vq.push_back(mk(1, 0, 1, 0, 0, 8'h00, ex(8'h6B, 1, 1, 0, 0)));
    vq.push_back(mk(1, 0, 1, 0, 0, 8'h00, ex(8'h00, 0, 0, 0, 0)));
    vq.push_back(mk(1, 0, 1, 0, 0, 8'h00, ex(8'h00, 0, 0, 0, 1)));
    vq.push_back(mk(1, 0, 1, 0, 1, 8'h00, ex(8'h00, 0, 0, 0, 1)));
    vq.push_back(mk(1, 0, 0, 0, 1, 8'h00, ex(8'h00, 0, 0, 0, 0)));

    for (int i = 0; i < vq.size(); i++) begin
      idle_inputs();
      if (vq[i].fw) begin
        f_wr = vq[i].wr; f_rd = vq[i].rd; f_flush = vq[i].flush;
        f_clr = vq[i].clr; f_wdata = vq[i].wdata;
      end else begin
        s_wr = vq[i].wr; s_rd = vq[i].rd; s_flush = vq[i].flush;
        s_clr = vq[i].clr; s_wdata = vq[i].wdata;
      end
      cycle();
      if (vq[i].fw)
        check($sformatf("fwft_vec%0d", i), f_obs, vq[i].exp,
              vq[i].exp[9] ? ALL : NO_DATA);
      else
        check($sformatf("std_vec%0d", i), s_obs, vq[i].exp, ALL);
    end

    // Async reset mid-burst at count 4, between clock edges.
    std_op(1, 0, 8'hD1);
    std_op(1, 0, 8'hD2);
    std_op(1, 0, 8'hD3);
    std_op(1, 0, 8'hD4);
    std_op(1, 0, 8'hD5);
    std_op(1, 1, 8'hD6);
    check("pre_reset", s_obs, ex(8'hD1, 1, 4, 1, 0), ALL);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", s_obs, ex(8'h00, 0, 0, 0, 0), ALL);
    idle_inputs();
    cycle();
    rst_n = 1'b1;
    std_op(1, 0, 8'hC5);
    check("post_reset_wr", s_obs, ex(8'h00, 0, 1, 0, 0), ALL);
    std_op(0, 1, 8'h00);
    check("post_reset_rd", s_obs, ex(8'hC5, 1, 0, 0, 0), ALL);

    idle_inputs();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
